free_list_bank: RTL and testbench
=================================

FREE_LIST_BANK -- requirements
Module: free_list_bank

Interface
REQ-001 SHALL have parameter BANK_INDEX, default 0, meaning the PRF bank (0..PRF_BANK_COUNT-1) this free list serves.
REQ-002 SHALL have parameter DEPTH, default FREE_LIST_LENGTH_PER_BANK (32), meaning entry count.
REQ-003 SHALL have parameter RESET_FREE_COUNT, default 24, meaning PRs free at reset: PR_COUNT/PRF_BANK_COUNT minus AR_COUNT/PRF_BANK_COUNT.
REQ-004 CLK  input  1  clock; single clock domain, all state on rising edge.
REQ-005 nRST  input  1  reset, synchronous and active-low.
REQ-006 enq_valid  input  1  ROB retire side returns a freed PR.
REQ-007 enq_PR_tag  input  LOG_PR_COUNT (7)  freed PR; bits [1:0] are bank, bits [6:2] are index.
REQ-008 enq_ready  output  1  space available.
REQ-009 deq_valid  output  1  a free PR is available to rename.
REQ-010 deq_PR_tag  output  7  free PR at head.
REQ-011 deq_ready  input  1  rename consumes the head PR.
REQ-012 count  output  6  current free entries, 0..32.
REQ-013 below_lower  output  1  count < FREE_LIST_LOWER_THRESHOLD (8).
REQ-014 at_or_above_upper  output  1  count >= FREE_LIST_UPPER_THRESHOLD (24).
REQ-015 bank_error  output  1  sticky: an accepted enqueue carried the wrong bank bits.

Function
REQ-016 Storage SHALL be a circular FIFO of DEPTH entries, each 5 bits wide (PR index only), with 5-bit head and tail pointers that wrap 31->0 naturally.
REQ-017 deq_PR_tag SHALL equal {mem[head], BANK_INDEX[1:0]}, read combinationally from registered storage; value is don't-care when deq_valid=0.
REQ-018 deq_valid SHALL be (count != 0); enq_ready SHALL be (count != DEPTH); neither depends on the other side's handshake in the same cycle.
REQ-019 Enqueue fires on enq_valid & enq_ready: mem[tail] <= enq_PR_tag[6:2]; tail increments.
REQ-020 Dequeue fires on deq_valid & deq_ready: head increments.
REQ-021 Both firing in one cycle: both pointers advance, count unchanged.
REQ-022 count SHALL change by +1 for enqueue only, -1 for dequeue only, 0 otherwise; it never exceeds DEPTH nor drops below 0.
REQ-023 Empty: no bypass; a PR enqueued in cycle N is first visible on deq_PR_tag in cycle N+1.
REQ-024 Full: enq_valid is ignored (not stored) even if a dequeue fires the same cycle.
REQ-025 Threshold outputs SHALL be combinational from registered count.
REQ-026 bank_error SHALL set the cycle after an enqueue fires with enq_PR_tag[1:0] != BANK_INDEX; the entry is still stored; the flag clears only on reset.

Reset
REQ-027 On nRST=0 at a clock edge: mem[i] <= 8+i for i=0..23 (others don't-care), head <= 0, tail <= 24, count <= 24, bank_error <= 0.
REQ-028 Post-reset outputs: deq_valid=1, deq_PR_tag={5'd8,BANK_INDEX}, enq_ready=1, below_lower=0, at_or_above_upper=1.
REQ-029 Reset asserted mid-operation SHALL override any same-cycle enqueue/dequeue.

Structure
REQ-030 PR_COUNT, LOG_PR_COUNT, PRF_BANK_COUNT, FREE_LIST_LENGTH_PER_BANK, LOG_FREE_LIST_LENGTH_PER_BANK and both FREE_LIST thresholds SHALL come from core_types_pkg; no local redefinition.
REQ-031 No sub-module; the enclosing free_list instantiates PRF_BANK_COUNT copies with BANK_INDEX 0..3.

Verification
REQ-032 Reset with BANK_INDEX=1 -> deq_PR_tag=7'd33, count=24, deq_valid=1, enq_ready=1, at_or_above_upper=1.
REQ-033 BANK_INDEX=0, deq_ready=1 for 24 cycles -> tags 32,36,...,124 in order; then deq_valid=0, count=0, below_lower=1.
REQ-034 From empty, enqueue tag 7'd8 -> deq_valid=0 that cycle, next cycle deq_valid=1 and deq_PR_tag=8.
REQ-035 From reset, 8 enqueues -> count=32, enq_ready=0; enqueue attempt with deq_ready=1 -> count 31, attempted tag absent from later dequeues.
REQ-036 Simultaneous enq/deq across pointer wrap (tail 31->0) for 40 cycles -> count constant, FIFO order preserved.
REQ-037 BANK_INDEX=2, enqueue tag 7'd5 -> bank_error=1 next cycle, stays 1 until nRST=0.

Source files
------------

// File: rtl/core_types_pkg.sv
//------------------------------------------------------------------------------
// core_types_pkg
// Core-wide physical register and free-list sizing constants.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package core_types_pkg;

    localparam int AR_COUNT                       = 32;
    localparam int PR_COUNT                       = 128;
    localparam int LOG_PR_COUNT                   = 7;
    localparam int PRF_BANK_COUNT                 = 4;
    localparam int LOG_PRF_BANK_COUNT             = 2;
    localparam int FREE_LIST_LENGTH_PER_BANK      = PR_COUNT / PRF_BANK_COUNT;
    localparam int LOG_FREE_LIST_LENGTH_PER_BANK  = 5;
    localparam int FREE_LIST_LOWER_THRESHOLD      = 8;
    localparam int FREE_LIST_UPPER_THRESHOLD      = 24;

endpackage : core_types_pkg

`default_nettype wire

// File: rtl/free_list_bank.sv
//------------------------------------------------------------------------------
// free_list_bank
// Per-bank circular FIFO of free physical register indices for rename.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module free_list_bank
    import core_types_pkg::*;
#(
    parameter int BANK_INDEX       = 0,
    parameter int DEPTH            = FREE_LIST_LENGTH_PER_BANK,
    parameter int RESET_FREE_COUNT = 24
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    enq_valid,
    input  logic [LOG_PR_COUNT-1:0] enq_PR_tag,
    output logic                    enq_ready,
    output logic                    deq_valid,
    output logic [LOG_PR_COUNT-1:0] deq_PR_tag,
    input  logic                    deq_ready,
    output logic [LOG_FREE_LIST_LENGTH_PER_BANK:0] count,
    output logic                    below_lower,
    output logic                    at_or_above_upper,
    output logic                    bank_error
);

    localparam int IDX_W       = LOG_FREE_LIST_LENGTH_PER_BANK;
    localparam int CNT_W       = LOG_FREE_LIST_LENGTH_PER_BANK + 1;
    localparam int AR_PER_BANK = AR_COUNT / PRF_BANK_COUNT;
    localparam logic [LOG_PRF_BANK_COUNT-1:0] c_BANK_BITS = LOG_PRF_BANK_COUNT'(BANK_INDEX);

    logic [IDX_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_bank_error;

    logic w_enq_fire;
    logic w_deq_fire;

    assign enq_ready  = (r_count != CNT_W'(DEPTH));
    assign deq_valid  = (r_count != '0);
    assign w_enq_fire = enq_valid & enq_ready;
    assign w_deq_fire = deq_valid & deq_ready;

    assign deq_PR_tag        = {r_mem[r_head], c_BANK_BITS};
    assign count             = r_count;
    assign below_lower       = (r_count <  CNT_W'(FREE_LIST_LOWER_THRESHOLD));
    assign at_or_above_upper = (r_count >= CNT_W'(FREE_LIST_UPPER_THRESHOLD));
    assign bank_error        = r_bank_error;

    // Reset preloads indices above the architectural mapping; upper entries stay unreset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < RESET_FREE_COUNT; i++) begin
                r_mem[i] <= IDX_W'(AR_PER_BANK + i);
            end
        end else if (w_enq_fire) begin
            r_mem[r_tail] <= enq_PR_tag[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_head       <= '0;
            r_tail       <= IDX_W'(RESET_FREE_COUNT);
            r_count      <= CNT_W'(RESET_FREE_COUNT);
            r_bank_error <= 1'b0;
        end else begin
            if (w_enq_fire) begin
                r_tail <= r_tail + 1'b1;
                if (enq_PR_tag[LOG_PRF_BANK_COUNT-1:0] != c_BANK_BITS) begin
                    r_bank_error <= 1'b1;
                end
            end
            if (w_deq_fire) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : free_list_bank

`default_nettype wire

// File: tb/tb_free_list_bank.sv
//------------------------------------------------------------------------------
// tb_free_list_bank
// Directed self-checking bench for free_list_bank across three bank indices.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_free_list_bank;

    logic       CLK;
    logic       nRST;
    logic       enq_valid;
    logic [6:0] enq_PR_tag;
    logic       deq_ready;

    logic       enq_ready_w  [3];
    logic       deq_valid_w  [3];
    logic [6:0] deq_tag_w    [3];
    logic [5:0] count_w      [3];
    logic       below_w      [3];
    logic       upper_w      [3];
    logic       bank_err_w   [3];

    int n_checks;
    int n_pass;
    int q[$];

    generate
        for (genvar b = 0; b < 3; b++) begin : g_dut
            free_list_bank #(
                .BANK_INDEX       (b),
                .DEPTH            (32),
                .RESET_FREE_COUNT (24)
            ) u_dut (
                .CLK               (CLK),
                .nRST              (nRST),
                .enq_valid         (enq_valid),
                .enq_PR_tag        (enq_PR_tag),
                .enq_ready         (enq_ready_w[b]),
                .deq_valid         (deq_valid_w[b]),
                .deq_PR_tag        (deq_tag_w[b]),
                .deq_ready         (deq_ready),
                .count             (count_w[b]),
                .below_lower       (below_w[b]),
                .at_or_above_upper (upper_w[b]),
                .bank_error        (bank_err_w[b])
            );
        end
    endgenerate

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Bank-0 reset contents: indices 8..31 -> tags 32,36,...,124.
    task automatic do_reset();
        nRST       = 1'b0;
        enq_valid  = 1'b0;
        deq_ready  = 1'b0;
        enq_PR_tag = '0;
        step();
        nRST = 1'b1;
        q.delete();
        for (int i = 0; i < 24; i++) q.push_back((8 + i) * 4);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        do_reset();

        check("rst_tag_b1",   deq_tag_w[1],  33);
        check("rst_tag_b0",   deq_tag_w[0],  32);
        check("rst_count_b1", count_w[1],    24);
        check("rst_dvalid",   deq_valid_w[1], 1);
        check("rst_eready",   enq_ready_w[1], 1);
        check("rst_upper",    upper_w[1],    1);
        check("rst_lower",    below_w[1],    0);
        check("rst_berr",     bank_err_w[1], 0);

        // Drain all 24 reset entries, crossing both thresholds.
        deq_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            check("drain_tag",   deq_tag_w[0], q.pop_front());
            check("drain_count", count_w[0],   24 - i);
            check("drain_lower", below_w[0],   32'((24 - i) < 8));
            check("drain_upper", upper_w[0],   32'((24 - i) >= 24));
            step();
        end
        check("empty_dvalid", deq_valid_w[0], 0);
        check("empty_count",  count_w[0],     0);
        check("empty_lower",  below_w[0],     1);
        step();
        check("underflow_count", count_w[0], 0);

        // Enqueue into empty with dequeue requested: no bypass.
        enq_valid  = 1'b1;
        enq_PR_tag = 7'd8;
        check("nobypass_dvalid", deq_valid_w[0], 0);
        step();
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("enq_vis_dvalid", deq_valid_w[0], 1);
        check("enq_vis_tag",    deq_tag_w[0],   8);
        check("enq_vis_count",  count_w[0],     1);

        // Fill to full, then a dropped enqueue alongside a dequeue.
        do_reset();
        enq_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enq_PR_tag = 7'(i * 4);
            q.push_back(i * 4);
            step();
        end
        enq_valid = 1'b0;
        check("full_count",  count_w[0],     32);
        check("full_eready", enq_ready_w[0], 0);
        check("full_upper",  upper_w[0],     1);
        enq_valid  = 1'b1;
        enq_PR_tag = 7'd100;
        deq_ready  = 1'b1;
        check("full_head", deq_tag_w[0], q.pop_front());
        step();
        enq_valid = 1'b0;
        check("full_drop_count",  count_w[0],     31);
        check("full_drop_eready", enq_ready_w[0], 1);
        for (int i = 0; i < 31; i++) begin
            check("full_drain_tag", deq_tag_w[0], q.pop_front());
            step();
        end
        check("full_drain_dvalid", deq_valid_w[0], 0);
        deq_ready = 1'b0;

        // Simultaneous enqueue/dequeue across the tail wrap.
        do_reset();
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            enq_PR_tag = 7'((i % 32) * 4);
            check("wrap_tag", deq_tag_w[0], q.pop_front());
            q.push_back((i % 32) * 4);
            step();
            check("wrap_count", count_w[0], 24);
        end
        enq_valid = 1'b0;
        for (int i = 0; i < 24; i++) begin
            check("wrap_drain_tag", deq_tag_w[0], q.pop_front());
            step();
        end
        check("wrap_drain_dvalid", deq_valid_w[0], 0);

        // Reset overrides same-cycle handshakes.
        nRST       = 1'b0;
        enq_valid  = 1'b1;
        enq_PR_tag = 7'd5;
        deq_ready  = 1'b1;
        step();
        nRST      = 1'b1;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("rstov_count", count_w[0],    24);
        check("rstov_tag",   deq_tag_w[0],  32);
        check("rstov_berr2", bank_err_w[2], 0);

        // Wrong-bank enqueue sets sticky flag; correct bank stays clear.
        enq_valid  = 1'b1;
        enq_PR_tag = 7'd5;
        step();
        enq_valid = 1'b0;
        check("berr_b2",     bank_err_w[2], 1);
        check("berr_b0",     bank_err_w[0], 1);
        check("berr_b1",     bank_err_w[1], 0);
        check("berr_count",  count_w[2],    25);
        step();
        step();
        step();
        check("berr_sticky", bank_err_w[2], 1);
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        check("berr_clear",  bank_err_w[2], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_free_list_bank

`default_nettype wire
